// File: rtl/arc4_crack_ctrl_if.sv
// -----------------------------------------------------------------------------
// arc4_crack_ctrl_if
//   Bundle of every non-clock signal around the key-search controller: the
//   host-side start/result handshake, the arc4 start handshake and the
//   snooped plaintext write port.
//
//   Handshake semantics (single definition for the whole block):
//     host  : en is a request sampled only on a clock edge where rdy=1; an
//             edge with en=1 and rdy=1 is an accepted start. rdy falls in the
//             following cycle and rises again when key/key_valid hold the
//             verdict of the search.
//     arc4  : arc4_en is a one-cycle pulse issued only while arc4_rdy=1;
//             arc4 then drops arc4_rdy and raises it again when finished.
//             arc4_key is valid from the pulse until the next pulse.
//     snoop : every cycle with pt_wren=1 carries one plaintext byte
//             (pt_wrdata) for address pt_addr; no back-pressure exists.
//
//   Modports:
//     slave  : the controller (drives rdy, key, key_valid, arc4_en, arc4_key)
//     master : its environment (host, arc4 core, or a testbench)
// -----------------------------------------------------------------------------
interface arc4_crack_ctrl_if #(
  parameter int unsigned KEY_W = 24
);
  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key_start;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             arc4_en;
  logic             arc4_rdy;
  logic [KEY_W-1:0] arc4_key;
  logic             pt_wren;
  logic [7:0]       pt_addr;
  logic [7:0]       pt_wrdata;

  modport master (
    output en, key_start, arc4_rdy, pt_wren, pt_addr, pt_wrdata,
    input  rdy, key, key_valid, arc4_en, arc4_key
  );

  modport slave (
    input  en, key_start, arc4_rdy, pt_wren, pt_addr, pt_wrdata,
    output rdy, key, key_valid, arc4_en, arc4_key
  );
endinterface

// File: rtl/arc4_crack_ctrl.sv
// -----------------------------------------------------------------------------
// arc4_crack_ctrl
//   Brute-force key-search controller. Starting at key_start it runs one arc4
//   decryption per candidate key, watches the plaintext bytes arc4 writes and
//   stops on the first candidate whose message bytes (address 1 upward) are
//   all printable, or after trying KEY_LAST.
//
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     bus      if   arc4_crack_ctrl_if.slave (host handshake, arc4 handshake,
//                   plaintext snoop)
//     state_o  out  current FSM state, for observation only
//
//   All outputs are registered; arc4_en is the only pulse.
// -----------------------------------------------------------------------------
module arc4_crack_ctrl #(
  parameter int unsigned      KEY_W    = 24,
  parameter logic [KEY_W-1:0] KEY_LAST = {KEY_W{1'b1}},
  parameter logic [7:0]       MIN_CHAR = 8'h20,
  parameter logic [7:0]       MAX_CHAR = 8'h7E
) (
  input  logic                    clk,
  input  logic                    rst_n,
  arc4_crack_ctrl_if.slave        bus,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_CHECK     = 3'd4
  } state_t;

  localparam logic [KEY_W-1:0] KEY_ONE = {{(KEY_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [KEY_W-1:0] cur_key_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] arc4_key_q;
  logic             bad_q;
  logic             rdy_q;
  logic             key_valid_q;
  logic             arc4_en_q;

  logic             byte_bad;
  logic             bad_d;

  // Address 0 carries the message length, not text, so it is never judged.
  assign byte_bad = bus.pt_wren && (bus.pt_addr != 8'd0) &&
                    ((bus.pt_wrdata < MIN_CHAR) || (bus.pt_wrdata > MAX_CHAR));
  assign bad_d    = bad_q | byte_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_key_q   <= '0;
      key_q       <= '0;
      arc4_key_q  <= '0;
      bad_q       <= 1'b0;
      rdy_q       <= 1'b1;
      key_valid_q <= 1'b0;
      arc4_en_q   <= 1'b0;
    end else begin
      arc4_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.en) begin
            cur_key_q   <= bus.key_start;
            key_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
            state_q     <= S_START;
          end
        end
        S_START: begin
          // arc4_key and the pulse leave this state on the same edge, so
          // arc4 always sees the new key together with its start request.
          arc4_key_q <= cur_key_q;
          bad_q      <= 1'b0;
          if (bus.arc4_rdy) begin
            arc4_en_q <= 1'b1;
            state_q   <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          bad_q <= bad_d;
          if (!bus.arc4_rdy) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // A write arriving together with arc4_rdy still lands in bad_q
          // before CHECK looks at it.
          bad_q <= bad_d;
          if (bus.arc4_rdy) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!bad_q) begin
            key_q       <= cur_key_q;
            key_valid_q <= 1'b1;
            rdy_q       <= 1'b1;
            state_q     <= S_IDLE;
          end else if (cur_key_q >= KEY_LAST) begin
            // >= also ends a search whose key_start was beyond KEY_LAST
            // after its single attempt, and keeps the counter from wrapping.
            key_q       <= cur_key_q;
            key_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cur_key_q <= cur_key_q + KEY_ONE;
            state_q   <= S_START;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.arc4_en   = arc4_en_q;
  assign bus.arc4_key  = arc4_key_q;
  assign state_o       = state_q;

endmodule
